// File: rtl/fracnet_product_accumulator.sv
// Sums each in_last-delimited group of unsigned products into one saturated result with beat count and clamp flag.
// Result registered on the edge accepting in_last; one HOLD bubble per group, in_ready depends on registered state only.
module fracnet_product_accumulator #(
    parameter int DIN_WIDTH = 19,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [DIN_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_sat,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 run;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 sat_flag;
    logic                 sat_next;
    logic [ACC_WIDTH:0]   sum;
    logic                 accept;

    // run stays low until the first edge after reset release, keeping in_ready low during reset
    assign in_ready  = run && (state == ACC);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // one extra bit so the carry-out flags overflow of the running sum
    assign sum      = {1'b0, acc} + {{(ACC_WIDTH + 1 - DIN_WIDTH){1'b0}}, in_data};
    assign acc_next = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    assign cnt_next = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    assign sat_next = sat_flag | sum[ACC_WIDTH];

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (accept && in_last) state_next = HOLD;
            HOLD:    if (out_ready)         state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= ACC;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                out_data  <= acc_next;
                out_count <= cnt_next;
                out_sat   <= sat_next;
                acc       <= '0;
                cnt       <= '0;
                sat_flag  <= 1'b0;
            end else begin
                acc      <= acc_next;
                cnt      <= cnt_next;
                sat_flag <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_fracnet_product_accumulator.sv
// Directed-vector bench for fracnet_product_accumulator, narrow 20-bit accumulator so saturation is reachable.
module tb_fracnet_product_accumulator;

    localparam int DW = 19;
    localparam int AW = 20;
    localparam int CW = 16;

    logic          ap_clk;
    logic          ap_rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_sat;
    logic          out_valid;
    logic          out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    fracnet_product_accumulator #(
        .DIN_WIDTH(DW),
        .ACC_WIDTH(AW),
        .CNT_WIDTH(CW)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got running, need finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // single beat: waits (bounded) for in_ready, then drops in_valid after the accepting edge
    task automatic beat(input logic [DW-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("beat_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int d, input int c, input logic s);
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_count"}, 32'(out_count), 32'(c));
        check({tag, "_sat"},   32'(out_sat),   32'(s));
        step();
    endtask

    initial begin
        ap_rst    = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // reset state
        idle(3);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_sat",   32'(out_sat),   32'd0);
        ap_rst = 1'b0;
        #2;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check("rel_in_ready_high", 32'(in_ready), 32'd1);

        // basic group with in_valid held high
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 19'd100;
        step();
        in_data = 19'd200;
        step();
        check("basic_mid_ready", 32'(in_ready),  32'd1);
        check("basic_mid_valid", 32'(out_valid), 32'd0);
        in_data = 19'd300;
        in_last = 1'b1;
        step();
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_data",  32'(out_data),  32'd600);
        check("basic_count", 32'(out_count), 32'd3);
        check("basic_sat",   32'(out_sat),   32'd0);
        check("basic_bubble_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        check("basic_after_valid", 32'(out_valid), 32'd0);
        check("basic_after_ready", 32'(in_ready),  32'd1);
        check("basic_after_data",  32'(out_data),  32'd600);

        // saturation, then confirm the flag does not leak into the next group
        beat(19'd524287, 1'b0);
        beat(19'd524287, 1'b0);
        beat(19'd524287, 1'b0);
        beat(19'd524287, 1'b1);
        expect_result("max", 1048575, 4, 1'b1);
        beat(19'd5, 1'b1);
        expect_result("post_max", 5, 1, 1'b0);

        // backpressure with a pending beat waiting on the input
        out_ready = 1'b0;
        beat(19'd7, 1'b1);
        in_valid = 1'b1;
        in_data  = 19'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data",  32'(out_data),  32'd7);
            check("bp_ready", 32'(in_ready),  32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_release_ready", 32'(in_ready),  32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_data",  32'(out_data),  32'd9);
        check("bp_next_count", 32'(out_count), 32'd1);
        step();

        // idle gaps inside a group
        beat(19'd3, 1'b0);
        idle(5);
        check("gap_no_valid", 32'(out_valid), 32'd0);
        beat(19'd4, 1'b0);
        idle(5);
        beat(19'd5, 1'b1);
        expect_result("gap", 12, 3, 1'b0);

        // asynchronous reset mid-group discards the partial sum
        beat(19'd10, 1'b0);
        beat(19'd20, 1'b0);
        #2;
        ap_rst = 1'b1;
        #1;
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        check("midrst_out_sat",   32'(out_sat),   32'd0);
        step();
        ap_rst = 1'b0;
        #2;
        check("midrst_rel_ready", 32'(in_ready), 32'd0);
        step();
        beat(19'd1, 1'b0);
        beat(19'd1, 1'b1);
        expect_result("midrst_next", 2, 2, 1'b0);

        // single-beat groups back-to-back with in_valid held high
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = DW'(i);
            check("single_ready", 32'(in_ready), 32'd1);
            step();
            check("single_valid", 32'(out_valid), 32'd1);
            check("single_data",  32'(out_data),  32'(i));
            check("single_count", 32'(out_count), 32'd1);
            check("single_bubble", 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("single_end_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
